mem_arbiter: RTL and testbench

- Shares the single main data memory between the instruction cache and the data cache.
- Accepts one miss transaction at a time from each cache, arbitrates round-robin, latches the winner's command and forwards it to memory.
- Returns memory busywait and readdata to the winner and stalls the loser.
- Optionally keeps a dcache writeback and its refill atomic. Sits between both cache FSMs and the memory model.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_rr_pick2.sv | 20 ++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data cache memory arbiter.
// Holds the FSM state encodings, the debug grant codes and the
// requester identifiers used by the round-robin picker.
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT_I = 2'd1;
  localparam logic [1:0] ST_GRANT_D = 2'd2;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

  // Encoding of the "last served" register.
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker for the memory arbiter.
// Ports:
//   req_i - icache is requesting
//   req_d - dcache is requesting
//   last  - requester served most recently (REQ_I / REQ_D)
//   pick  - winner: 0 = icache, 1 = dcache (meaningful only when a request is present)
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last,
  output logic pick
);

  // dcache wins when it is alone, or on a tie when the icache was not the one
  // it should yield to (i.e. the dcache was not served last).
  assign pick = req_d & (~req_i | (last != REQ_D));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one main memory between the icache and the dcache.
// One miss transaction at a time is accepted from each cache; the winner's
// command is latched and forwarded to memory, memory busywait/readdata are
// returned to the winner and the loser is stalled.
// Ports:
//   clock, reset (async, active-low)
//   i_read, i_address -> i_readdata, i_busywait           : icache side
//   d_read, d_write, d_address, d_writedata
//                     -> d_readdata, d_busywait           : dcache side
//   mem_read, mem_write, mem_address, mem_writedata
//                     <- mem_readdata, mem_busywait       : memory side
//   grant : debug, 00 none, 01 icache, 10 dcache
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 6,
  parameter int DATA_W         = 32,
  parameter bit LOCK_DCACHE_WB = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait,
  output logic [1:0]        grant
);

  logic [1:0]        state;
  logic              last;
  logic              started;
  logic              cmd_read;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;

  logic req_i;
  logic req_d;
  logic pick;
  logic gnt_i;
  logic gnt_d;
  logic hold;
  logic done;

  assign req_i = i_read;
  assign req_d = d_read | d_write;

  rr_pick2 u_pick (
    .req_i (req_i),
    .req_d (req_d),
    .last  (last),
    .pick  (pick)
  );

  assign gnt_i = (state == ST_GRANT_I);
  assign gnt_d = (state == ST_GRANT_D);

  // Gap cycle after a locked dcache writeback: dcache still owns the memory
  // but no command is latched until its refill read shows up.
  assign hold = gnt_d & ~cmd_read & ~cmd_write;

  // Memory must have gone busy at least once before a low busywait means
  // the transaction has finished.
  assign done = (gnt_i | gnt_d) & started & ~mem_busywait;

  assign mem_read      = cmd_read & ~done;
  assign mem_write     = cmd_write & ~done;
  assign mem_address   = cmd_addr;
  assign mem_writedata = cmd_data;

  assign grant = gnt_d ? GNT_D : (gnt_i ? GNT_I : GNT_NONE);

  assign i_readdata = gnt_i ? mem_readdata : '0;
  assign d_readdata = gnt_d ? mem_readdata : '0;

  // Busywaits are forced low while reset is asserted so both caches see a
  // quiet bus the moment reset is applied, even with requests still high.
  assign i_busywait = reset & (gnt_i ? ~done : req_i);
  assign d_busywait = reset & (gnt_d ? (hold ? req_d : ~done) : req_d);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      last      <= REQ_I;
      started   <= 1'b0;
      cmd_read  <= 1'b0;
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_i | req_d) begin
            if (pick) begin
              state     <= ST_GRANT_D;
              cmd_write <= d_write;
              cmd_read  <= ~d_write;
              cmd_addr  <= d_address;
              cmd_data  <= d_write ? d_writedata : '0;
            end else begin
              state     <= ST_GRANT_I;
              cmd_write <= 1'b0;
              cmd_read  <= 1'b1;
              cmd_addr  <= i_address;
              cmd_data  <= '0;
            end
          end
        end
        ST_GRANT_I, ST_GRANT_D: begin
          if (hold) begin
            if (d_read) begin
              cmd_read <= 1'b1;
              cmd_addr <= d_address;
              cmd_data <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            if (mem_busywait) begin
              started <= 1'b1;
            end
            if (done) begin
              started   <= 1'b0;
              last      <= gnt_d ? REQ_D : REQ_I;
              cmd_read  <= 1'b0;
              cmd_write <= 1'b0;
              // A locked writeback keeps GRANT_D; clearing the command
              // above is what turns the next cycle into the hold gap.
              if (!(gnt_d && cmd_write && LOCK_DCACHE_WB)) begin
                state <= ST_IDLE;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: two instances (writeback lock on / off) each
// with a small behavioural memory. Expected memory commands are queued per
// instance as stimulus is issued; a monitor pops them as commands appear and
// checks read data when the winning cache is released.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct packed {
    logic [1:0]  gnt;
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } txn_t;

  localparam int LAT = 5;

  logic        clock;
  logic        reset;
  logic        i_read        [2];
  logic [5:0]  i_address     [2];
  logic [31:0] i_readdata    [2];
  logic        i_busywait    [2];
  logic        d_read        [2];
  logic        d_write       [2];
  logic [5:0]  d_address     [2];
  logic [31:0] d_writedata   [2];
  logic [31:0] d_readdata    [2];
  logic        d_busywait    [2];
  logic        mem_read      [2];
  logic        mem_write     [2];
  logic [5:0]  mem_address   [2];
  logic [31:0] mem_writedata [2];
  logic [31:0] mem_readdata  [2];
  logic        mem_busywait  [2];
  logic [1:0]  grant         [2];

  bit   mem_dead [2];
  int   mem_cnt  [2];

  txn_t q0[$];
  txn_t q1[$];
  txn_t cur[2];
  bit   have_cur[2];
  bit   prev_cmd[2];

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(6), .DATA_W(32), .LOCK_DCACHE_WB(1'b1)) u_lock (
    .clock(clock), .reset(reset),
    .i_read(i_read[0]), .i_address(i_address[0]), .i_readdata(i_readdata[0]), .i_busywait(i_busywait[0]),
    .d_read(d_read[0]), .d_write(d_write[0]), .d_address(d_address[0]), .d_writedata(d_writedata[0]),
    .d_readdata(d_readdata[0]), .d_busywait(d_busywait[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_address(mem_address[0]),
    .mem_writedata(mem_writedata[0]), .mem_readdata(mem_readdata[0]), .mem_busywait(mem_busywait[0]),
    .grant(grant[0])
  );

  mem_arbiter #(.ADDR_W(6), .DATA_W(32), .LOCK_DCACHE_WB(1'b0)) u_nolock (
    .clock(clock), .reset(reset),
    .i_read(i_read[1]), .i_address(i_address[1]), .i_readdata(i_readdata[1]), .i_busywait(i_busywait[1]),
    .d_read(d_read[1]), .d_write(d_write[1]), .d_address(d_address[1]), .d_writedata(d_writedata[1]),
    .d_readdata(d_readdata[1]), .d_busywait(d_busywait[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_address(mem_address[1]),
    .mem_writedata(mem_writedata[1]), .mem_readdata(mem_readdata[1]), .mem_busywait(mem_busywait[1]),
    .grant(grant[1])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  function automatic logic [31:0] init_val(input logic [5:0] a);
    if (a == 6'h05) return 32'hA5A5_0001;
    return 32'hC0DE_0000 | {26'd0, a};
  endfunction

  // Memory: goes busy the cycle after a command, stays busy LAT cycles,
  // then drops busywait with the read data.
  always @(posedge clock or negedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        mem_busywait[k] <= 1'b0;
        mem_cnt[k]      <= 0;
        mem_readdata[k] <= '0;
      end else if (!mem_dead[k]) begin
        if (mem_cnt[k] == 0) begin
          if ((mem_read[k] || mem_write[k]) && !mem_busywait[k]) begin
            mem_busywait[k] <= 1'b1;
            mem_cnt[k]      <= LAT;
          end
        end else if (mem_cnt[k] == 1) begin
          mem_busywait[k] <= 1'b0;
          mem_cnt[k]      <= 0;
          if (mem_read[k]) mem_readdata[k] <= init_val(mem_address[k]);
        end else begin
          mem_cnt[k] <= mem_cnt[k] - 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [1:0] g, input logic w,
                      input logic [5:0] a, input logic [31:0] d);
    txn_t t;
    t.gnt = g; t.wr = w; t.addr = a; t.data = d;
    if (k == 0) q0.push_back(t);
    else        q1.push_back(t);
  endtask

  task automatic mon(input int k);
    txn_t t;
    logic cmd, w_req, w_bw, l_req, l_bw;
    logic [31:0] w_rd, l_rd;
    if (!reset) begin
      have_cur[k] = 1'b0;
      prev_cmd[k] = 1'b0;
      return;
    end
    cmd = mem_read[k] | mem_write[k];
    if (cmd && !prev_cmd[k]) begin
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cmd inst%0d: got addr %0h grant %0h, required no command", k, mem_address[k], grant[k]);
      end else begin
        if (k == 0) t = q0.pop_front();
        else        t = q1.pop_front();
        cur[k] = t;
        have_cur[k] = 1'b1;
        chk($sformatf("cmd_grant%0d", k), 64'(grant[k]), 64'(t.gnt));
        chk($sformatf("cmd_write%0d", k), 64'(mem_write[k]), 64'(t.wr));
        chk($sformatf("cmd_read%0d", k), 64'(mem_read[k]), 64'(!t.wr));
        chk($sformatf("cmd_addr%0d", k), 64'(mem_address[k]), 64'(t.addr));
        chk($sformatf("cmd_wdata%0d", k), 64'(mem_writedata[k]), 64'(t.wr ? t.data : 32'd0));
        l_req = (t.gnt == GNT_D) ? i_read[k] : (d_read[k] | d_write[k]);
        l_bw  = (t.gnt == GNT_D) ? i_busywait[k] : d_busywait[k];
        chk($sformatf("loser_stall%0d", k), 64'(l_bw), 64'(l_req));
      end
    end else if (have_cur[k]) begin
      w_req = (cur[k].gnt == GNT_D) ? (d_read[k] | d_write[k]) : i_read[k];
      w_bw  = (cur[k].gnt == GNT_D) ? d_busywait[k] : i_busywait[k];
      w_rd  = (cur[k].gnt == GNT_D) ? d_readdata[k] : i_readdata[k];
      l_rd  = (cur[k].gnt == GNT_D) ? i_readdata[k] : d_readdata[k];
      if (w_req && !w_bw) begin
        if (!cur[k].wr) chk($sformatf("rdata%0d", k), 64'(w_rd), 64'(cur[k].data));
        chk($sformatf("loser_rdata%0d", k), 64'(l_rd), 64'd0);
        have_cur[k] = 1'b0;
      end
    end
    prev_cmd[k] = cmd;
  endtask

  initial begin
    forever begin
      @(negedge clock);
      for (int k = 0; k < 2; k++) mon(k);
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // Cache-side driver: raise a request, hold it until the arbiter releases
  // the cache, then drop it.
  task automatic drive(input int k, input bit is_d, input bit wr,
                       input logic [5:0] a, input logic [31:0] wd);
    int n;
    if (is_d) begin
      d_address[k] = a; d_writedata[k] = wd; d_write[k] = wr; d_read[k] = !wr;
    end else begin
      i_address[k] = a; i_read[k] = 1'b1;
    end
    for (n = 0; n < 400; n++) begin
      @(negedge clock);
      if (reset && (is_d ? ((d_read[k] || d_write[k]) && !d_busywait[k])
                         : (i_read[k] && !i_busywait[k]))) break;
    end
    if (n == 400) begin
      checks++;
      errors++;
      $display("FAIL req_timeout inst%0d is_d=%0d addr %0h: got no release, required release", k, is_d, a);
    end
    #1;
    if (is_d) begin
      d_read[k] = 1'b0; d_write[k] = 1'b0;
    end else begin
      i_read[k] = 1'b0;
    end
  endtask

  task automatic dseq(input int k);
    drive(k, 1'b1, 1'b1, 6'h12, 32'hDEAD_BEEF);
    drive(k, 1'b1, 1'b0, 6'h2A, 32'd0);
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int n;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_read[k] = 0; i_address[k] = 0; d_read[k] = 0; d_write[k] = 0;
      d_address[k] = 0; d_writedata[k] = 0; mem_dead[k] = 0;
      have_cur[k] = 0; prev_cmd[k] = 0;
    end
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_grant%0d", k), 64'(grant[k]), 64'(GNT_NONE));
      chk($sformatf("rst_memrd%0d", k), 64'(mem_read[k] | mem_write[k]), 64'd0);
      chk($sformatf("rst_addr%0d", k), 64'(mem_address[k]), 64'd0);
      chk($sformatf("rst_wdata%0d", k), 64'(mem_writedata[k]), 64'd0);
      chk($sformatf("rst_bw%0d", k), 64'({i_busywait[k], d_busywait[k]}), 64'd0);
      chk($sformatf("rst_rdata%0d", k), 64'(i_readdata[k] | d_readdata[k]), 64'd0);
    end
    reset = 1'b1;

    // icache alone
    tick();
    push(0, GNT_I, 1'b0, 6'h05, 32'hA5A5_0001);
    fork drive(0, 1'b0, 1'b0, 6'h05, 32'd0); join_none
    #1;
    chk("t1_req_stall", 64'(i_busywait[0]), 64'd1);
    @(negedge clock);
    chk("t1_cmd_next_cycle", 64'({mem_read[0], grant[0], mem_address[0]}), 64'({1'b1, GNT_I, 6'h05}));
    wait fork;
    tick();
    chk("t1_grant_back", 64'(grant[0]), 64'(GNT_NONE));

    // simultaneous requests after reset: dcache first
    do_reset();
    tick();
    push(0, GNT_D, 1'b0, 6'h0A, 32'hC0DE_000A);
    push(0, GNT_I, 1'b0, 6'h0B, 32'hC0DE_000B);
    fork
      drive(0, 1'b1, 1'b0, 6'h0A, 32'd0);
      drive(0, 1'b0, 1'b0, 6'h0B, 32'd0);
    join_none
    for (n = 0; n < 200; n++) begin
      @(negedge clock);
      if (d_read[0] && !d_busywait[0]) break;
    end
    if (n == 200) begin
      checks++; errors++;
      $display("FAIL t2_d_done: got no dcache release, required release");
    end
    @(negedge clock);
    chk("t2_idle_gap", 64'({grant[0], i_busywait[0], mem_read[0]}), 64'({GNT_NONE, 1'b1, 1'b0}));
    @(negedge clock);
    chk("t2_i_cmd", 64'({grant[0], mem_read[0], mem_address[0]}), 64'({GNT_I, 1'b1, 6'h0B}));
    wait fork;

    // writeback + refill with icache pending, lock on (inst0) and off (inst1)
    tick();
    push(0, GNT_D, 1'b1, 6'h12, 32'hDEAD_BEEF);
    push(0, GNT_D, 1'b0, 6'h2A, 32'hC0DE_002A);
    push(0, GNT_I, 1'b0, 6'h07, 32'hC0DE_0007);
    push(1, GNT_D, 1'b1, 6'h12, 32'hDEAD_BEEF);
    push(1, GNT_I, 1'b0, 6'h07, 32'hC0DE_0007);
    push(1, GNT_D, 1'b0, 6'h2A, 32'hC0DE_002A);
    fork
      dseq(0);
      dseq(1);
      drive(0, 1'b0, 1'b0, 6'h07, 32'd0);
      drive(1, 1'b0, 1'b0, 6'h07, 32'd0);
    join_none
    wait fork;

    // continuous requests alternate D,I,D,I,D,I
    tick();
    for (int j = 0; j < 3; j++) begin
      push(0, GNT_D, 1'b0, 6'h20 + 6'(j), 32'hC0DE_0020 + j);
      push(0, GNT_I, 1'b0, 6'h30 + 6'(j), 32'hC0DE_0030 + j);
    end
    fork
      begin for (int j = 0; j < 3; j++) drive(0, 1'b1, 1'b0, 6'h20 + 6'(j), 32'd0); end
      begin for (int j = 0; j < 3; j++) drive(0, 1'b0, 1'b0, 6'h30 + 6'(j), 32'd0); end
    join_none
    wait fork;

    // address changed mid-grant
    tick();
    push(0, GNT_D, 1'b0, 6'h03, 32'hC0DE_0003);
    fork drive(0, 1'b1, 1'b0, 6'h03, 32'd0); join_none
    repeat (3) @(negedge clock);
    #1;
    d_address[0] = 6'h3F;
    @(negedge clock);
    chk("t5_addr_latched", 64'({mem_read[0], mem_address[0]}), 64'({1'b1, 6'h03}));
    wait fork;

    // memory never busy: grant held; then reset mid-read and re-arbitration
    tick();
    mem_dead[0] = 1'b1;
    push(0, GNT_I, 1'b0, 6'h09, 32'hC0DE_0009);
    fork drive(0, 1'b0, 1'b0, 6'h09, 32'd0); join_none
    repeat (20) @(negedge clock);
    chk("t6_grant_held", 64'({grant[0], mem_read[0], i_busywait[0]}), 64'({GNT_I, 1'b1, 1'b1}));
    #1;
    reset = 1'b0;
    #1;
    chk("t6_rst_cmd", 64'({mem_read[0], mem_write[0]}), 64'd0);
    chk("t6_rst_bw", 64'({i_busywait[0], d_busywait[0]}), 64'd0);
    chk("t6_rst_grant", 64'(grant[0]), 64'(GNT_NONE));
    push(0, GNT_I, 1'b0, 6'h09, 32'hC0DE_0009);
    mem_dead[0] = 1'b0;
    tick();
    reset = 1'b1;
    wait fork;

    tick();
    tick();
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("open_txn", 64'({have_cur[0], have_cur[1]}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
